// File: rtl/audio_pkg.sv
// Shared definitions for the audio frame loader: parameter defaults, the
// loader FSM state encoding and a small index-width helper.
package audio_pkg;

    localparam int AUDIO_N_DEF       = 100;
    localparam int AUDIO_W_DEF       = 32;
    localparam int AUDIO_TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } audio_state_e;

    // Bits needed to index n entries (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/audio_frame_buf.sv
// Frame buffer: N words of W bits with one write port. Every word is visible
// at once on a flattened bus so the min/max engine can scan the whole frame.
module audio_frame_buf
    import audio_pkg::*;
#(
    parameter int N  = AUDIO_N_DEF,
    parameter int W  = AUDIO_W_DEF,
    parameter int IW = idx_width(AUDIO_N_DEF)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [IW-1:0]  waddr,
    input  logic [W-1:0]   wdata,
    output logic [N*W-1:0] rdata
);

    for (genvar gi = 0; gi < N; gi++) begin : g_word
        logic [W-1:0] word_q;

        // Capture the incoming sample when it is addressed to this word.
        always_ff @(posedge clk) begin
            if (we && (waddr == IW'(gi))) begin
                word_q <= wdata;
            end
        end

        assign rdata[gi*W +: W] = word_q;
    end

endmodule

// File: rtl/audio_frame_loader.sv
// Audio frame loader: collects N samples into a frame buffer, kicks the
// min/max engine, waits (bounded) for its done, and holds the result until
// downstream takes it.
module audio_frame_loader
    import audio_pkg::*;
#(
    parameter int N       = AUDIO_N_DEF,
    parameter int W       = AUDIO_W_DEF,
    parameter int TIMEOUT = AUDIO_TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_sample,
    output logic [N*W-1:0] raw_audio,
    output logic           start,
    input  logic           d,
    input  logic [W-1:0]   eng_max,
    input  logic [W-1:0]   eng_min,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [W-1:0]   out_max,
    output logic [W-1:0]   out_min,
    output logic           err,
    output logic [15:0]    frame_cnt
);

    localparam int IW = idx_width(N);
    localparam int TW = $clog2(TIMEOUT + 1);

    audio_state_e  state_q, state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [W-1:0]  out_max_q, out_max_d;
    logic [W-1:0]  out_min_q, out_min_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          err_q, err_d;
    logic          accept;

    // Accepting is held off while reset is high so no sample leaks in.
    assign in_ready  = (state_q == ST_FILL) && !reset;
    assign accept    = in_valid && in_ready;
    assign start     = (state_q == ST_START) && !reset;
    assign res_valid = (state_q == ST_HOLD);
    assign out_max   = out_max_q;
    assign out_min   = out_min_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;

    audio_frame_buf #(
        .N  (N),
        .W  (W),
        .IW (IW)
    ) u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_idx_q),
        .wdata (in_sample),
        .rdata (raw_audio)
    );

    // Next-state, counters and result latch; tmo_q==0 marks the first WAIT
    // cycle, where a done left over from the previous frame is ignored.
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        tmo_d       = tmo_q;
        out_max_d   = out_max_q;
        out_min_d   = out_min_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (wr_idx_q == IW'(N - 1)) begin
                        wr_idx_d = '0;
                        state_d  = ST_START;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (d && (tmo_q != '0)) begin
                    out_max_d = eng_max;
                    out_min_d = eng_min;
                    tmo_d     = '0;
                    state_d   = ST_HOLD;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_FILL;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FILL;
            wr_idx_q    <= '0;
            tmo_q       <= '0;
            out_max_q   <= '0;
            out_min_q   <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            tmo_q       <= tmo_d;
            out_max_q   <= out_max_d;
            out_min_q   <= out_min_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_audio_frame_loader.sv
// Directed bench for audio_frame_loader: frame fill, start pulse, engine
// handshake, stale-done rejection, timeout, result hold and mid-frame reset.
module tb_audio_frame_loader;

    localparam int N  = 100;
    localparam int W  = 32;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_sample;
    logic [N*W-1:0] raw_audio;
    logic           start;
    logic           d;
    logic [W-1:0]   eng_max;
    logic [W-1:0]   eng_min;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   out_max;
    logic [W-1:0]   out_min;
    logic           err;
    logic [15:0]    frame_cnt;

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    always #5 clk = ~clk;

    audio_frame_loader #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .raw_audio (raw_audio),
        .start     (start),
        .d         (d),
        .eng_max   (eng_max),
        .eng_min   (eng_min),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .out_max   (out_max),
        .out_min   (out_min),
        .err       (err),
        .frame_cnt (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end else begin
            $display("ok   %s: %0d", tag, $signed(got));
        end
    endtask

    // Frame 0 is the reference frame; other frames use a simple ramp.
    function automatic logic [31:0] smp(input int f, input int k);
        if (f == 0) begin
            case (k)
                0:       return 32'(196608);
                1:       return 32'(458752);
                2:       return 32'(0);
                50:      return 32'(-1769472);
                99:      return 32'(-1441792);
                default: return 32'((k % 7) * 1024 - 3000);
            endcase
        end
        return 32'((k - 50) * 256 + f);
    endfunction

    // Streams n samples with in_valid held high; returns on the negedge after
    // the last accept.
    task automatic fill(input int f, input int n, output int bad_start, output int bad_rdy);
        bad_start = 0;
        bad_rdy   = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (start !== 1'b0) bad_start++;
            if (in_ready !== 1'b1) bad_rdy++;
            in_valid  = 1'b1;
            in_sample = smp(f, k);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int bs, br, bad;
        logic signed [31:0] mx, mn, v;

        reset = 1'b1; in_valid = 1'b0; in_sample = '0; d = 1'b0;
        eng_max = '0; eng_min = '0; res_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_max", out_max, 32'd0);
        check("rst_out_min", out_min, 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("fill_in_ready", 32'(in_ready), 32'd1);

        // Reference frame, start one cycle after the 100th accept
        fill(0, N, bs, br);
        check("f0_early_start", 32'(bs), 32'd0);
        check("f0_ready_gaps", 32'(br), 32'd0);
        check("f0_start", 32'(start), 32'd1);
        check("f0_start_in_ready", 32'(in_ready), 32'd0);
        check("f0_raw0", raw_audio[0*W +: W], 32'(196608));
        check("f0_raw1", raw_audio[1*W +: W], 32'(458752));
        check("f0_raw50", raw_audio[50*W +: W], 32'(-1769472));
        check("f0_raw99", raw_audio[99*W +: W], 32'(-1441792));
        mx = raw_audio[W-1:0];
        mn = raw_audio[W-1:0];
        for (int k = 1; k < N; k++) begin
            v = raw_audio[k*W +: W];
            if (v > mx) mx = v;
            if (v < mn) mn = v;
        end
        check("eng_model_max", mx, 32'(458752));
        check("eng_model_min", mn, 32'(-1769472));
        @(negedge clk);
        check("f0_start_single", 32'(start), 32'd0);
        check("f0_wait1_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        d = 1'b1; eng_max = mx; eng_min = mn;
        @(negedge clk);
        d = 1'b0;
        check("f0_res_valid", 32'(res_valid), 32'd1);
        check("f0_out_max", out_max, 32'(458752));
        check("f0_out_min", out_min, 32'(-1769472));
        check("f0_cnt_before_ack", 32'(frame_cnt), 32'd0);

        // Hold for 50 cycles with in_valid toggling and a stray done
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || res_valid !== 1'b1 || start !== 1'b0) bad++;
            if (out_max !== 32'(458752) || out_min !== 32'(-1769472)) bad++;
            in_valid  = i[0];
            in_sample = 32'(i * 123);
            d         = (i == 10);
            eng_max   = 32'(7);
            eng_min   = 32'(-7);
        end
        check("hold_stable", 32'(bad), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; d = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        check("ack_res_valid", 32'(res_valid), 32'd0);
        check("ack_in_ready", 32'(in_ready), 32'd1);
        check("ack_frame_cnt", 32'(frame_cnt), 32'd1);
        repeat (3) @(negedge clk);
        res_ready = 1'b0;
        check("idle_ack_frame_cnt", 32'(frame_cnt), 32'd1);
        check("idle_out_max", out_max, 32'(458752));

        // Done held from before start: ignored in the first WAIT cycle
        d = 1'b1; eng_max = 32'(1234567); eng_min = 32'(-1234567);
        fill(1, N, bs, br);
        check("f1_early_start", 32'(bs), 32'd0);
        check("f1_start", 32'(start), 32'd1);
        check("f1_raw0", raw_audio[0*W +: W], 32'(-12799));
        @(negedge clk);
        check("stale_wait1_res_valid", 32'(res_valid), 32'd0);
        check("stale_wait1_out_max", out_max, 32'(458752));
        @(negedge clk);
        check("stale_wait2_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        d = 1'b0;
        check("stale_res_valid", 32'(res_valid), 32'd1);
        check("stale_out_max", out_max, 32'(1234567));
        check("stale_out_min", out_min, 32'(-1234567));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("f1_frame_cnt", 32'(frame_cnt), 32'd2);

        // Engine never answers: err 16 cycles after entering WAIT
        fill(2, N, bs, br);
        check("f2_start", 32'(start), 32'd1);
        bad = 0;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            if (err !== 1'b0 || res_valid !== 1'b0) bad++;
        end
        check("tmo_no_early_err", 32'(bad), 32'd0);
        @(negedge clk);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_in_ready", 32'(in_ready), 32'd1);
        check("tmo_res_valid", 32'(res_valid), 32'd0);
        check("tmo_out_max", out_max, 32'(1234567));
        check("tmo_frame_cnt", 32'(frame_cnt), 32'd2);
        @(negedge clk);
        check("tmo_err_single", 32'(err), 32'd0);

        // Reset after 40 samples, with a done arriving around reset
        fill(3, 40, bs, br);
        reset = 1'b1; d = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_start", 32'(start), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_out_max", out_max, 32'd0);
        check("mid_rst_out_min", out_min, 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        d = 1'b0;
        fill(4, N, bs, br);
        check("f4_early_start", 32'(bs), 32'd0);
        check("f4_start", 32'(start), 32'd1);
        check("f4_raw0", raw_audio[0*W +: W], smp(4, 0));
        check("f4_raw99", raw_audio[99*W +: W], smp(4, 99));
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
